mem_burst_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares one asynchronous-read test-vector memory (DEPTH words × WIDTH bits) between NREQ requesters. Each requester asks for a burst of consecutive words from a start address. The block grants one requester at a time and walks the memory address with a wrapping counter. It drives the memory read enable, which gates the shared data bus, and returns registered read data tagged with the owner. It sits between the bench-side scan agents and the vector memory, replacing free-running counter-driven reads.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr_pick.sv | 38 +++
 rtl/mem_burst_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_burst_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory burst arbiter: FSM state encoding,
// default sizing and the burst-length clamp helper.
package mem_arb_pkg;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Requests longer than the memory read every word exactly once.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational winner selection: first set request at or after i_ptr, wrapping.
// With MEM_ARB_FIXED_PRIO_EN defined the lowest-index request always wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_any,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    int w_cand;

    always_comb begin
        o_any    = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_cand = k;
`else
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NREQ) w_cand = w_cand - NREQ;
`endif
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter for a shared asynchronous-read vector memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int OW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     start_addr,
    input  logic [NREQ*(AW+1)-1:0] burst_len,
    output logic [NREQ-1:0]        gnt,
    output logic                   mem_en,
    output logic [AW-1:0]          mem_addr,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [OW-1:0]          rd_owner,
    output logic [NREQ-1:0]        done,
    output arb_state_e             dbg_state
);

    // Handshake: req is a level held by the requester until its done pulse;
    // start_addr/burst_len are captured only on the arbitration edge, and each
    // rd_valid cycle carries exactly one beat with no backpressure.

    arb_state_e        r_state, w_state_nxt;
    logic [NREQ-1:0]   r_gnt_oh;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_rr;
    logic [AW-1:0]     r_ptr;
    logic [AW:0]       r_cnt;
    logic              r_rd_valid;
    logic [WIDTH-1:0]  r_rd_data;
    logic [OW-1:0]     r_rd_owner;

    logic              w_any;
    logic [NREQ-1:0]   w_pick_oh;
    logic [OW-1:0]     w_pick_idx;
    logic [AW-1:0]     w_start;
    logic [AW:0]       w_len_raw;
    logic [AW:0]       w_len;

    mem_arb_rr_pick #(.NREQ(NREQ), .IW(OW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_rr),
        .o_any    (w_any),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    assign w_start   = start_addr[w_pick_idx*AW +: AW];
    assign w_len_raw = burst_len[w_pick_idx*(AW+1) +: (AW+1)];
    assign w_len     = (AW+1)'(clamp_len(32'(w_len_raw), 32'(DEPTH)));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        mem_en      = 1'b0;
        done        = '0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = (w_len == '0) ? DONE : BURST;
            end
            BURST: begin
                gnt    = r_gnt_oh;
                mem_en = 1'b1;
                if (r_cnt == (AW+1)'(1)) w_state_nxt = DONE;
            end
            DONE: begin
                gnt         = r_gnt_oh;
                done        = r_gnt_oh;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_oh   <= '0;
            r_owner    <= '0;
            r_rr       <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_owner <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_oh <= w_pick_oh;
                        r_owner  <= w_pick_idx;
                        r_ptr    <= w_start;
                        r_cnt    <= w_len;
                    end
                end
                BURST: begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= mem_rdata;
                    r_rd_owner <= r_owner;
                    r_ptr      <= r_ptr + 1'b1;
                    r_cnt      <= r_cnt - 1'b1;
                end
                DONE: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    r_rr <= (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_ptr;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_owner  = r_rd_owner;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: directed burst scenarios followed by
// randomized requesters, checked against a transaction-level arbitration model.
module tb_mem_burst_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ  = 2;
    localparam int DEPTH = 16;
    localparam int WIDTH = 24;
    localparam int AW    = 4;
    localparam int OW    = 1;
    localparam int EW    = 16 + 8 + WIDTH;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*AW-1:0]     start_addr = '0;
    logic [NREQ*(AW+1)-1:0] burst_len = '0;
    logic [NREQ-1:0]        gnt;
    logic                   mem_en;
    logic [AW-1:0]          mem_addr;
    logic [WIDTH-1:0]       mem_rdata;
    logic                   rd_valid;
    logic [WIDTH-1:0]       rd_data;
    logic [OW-1:0]          rd_owner;
    logic [NREQ-1:0]        done;
    arb_state_e             dbg_state;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [EW-1:0] exp_q[$];
    logic [23:0]   done_q[$];

    // Clock / reset / memory
    always #5 clk = ~clk;
    assign mem_rdata = mem_en ? mem[mem_addr] : 24'hDEAD00;

    mem_burst_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .gnt        (gnt),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_owner   (rd_owner),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: one burst at a time; a granted burst of clamped length L
    // at edge e yields beats after edges e+1..e+L, done after edge e+L, and the
    // next arbitration no earlier than edge e+L+2.
    int m_rr = 0, m_next_free = 0, m_active = 0;
    int m_e = 0, m_len = 0, m_owner = 0, m_start = 0;
    int m_w, m_c, m_l;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (reset) begin
            exp_q.delete();
            done_q.delete();
            m_rr = 0;
            m_active = 0;
            m_next_free = edge_n + 1;
        end else if (edge_n >= m_next_free && req != '0) begin
            m_w = -1;
            for (int k = 0; k < NREQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                m_c = k;
`else
                m_c = (m_rr + k) % NREQ;
`endif
                if (m_w < 0 && req[m_c]) m_w = m_c;
            end
            m_l = int'(burst_len[m_w*(AW+1) +: (AW+1)]);
            if (m_l > DEPTH) m_l = DEPTH;
            m_active = 1;
            m_e = edge_n;
            m_len = m_l;
            m_owner = m_w;
            m_start = int'(start_addr[m_w*AW +: AW]);
            for (int i = 0; i < m_l; i++)
                exp_q.push_back({16'(edge_n + 1 + i), 8'(m_w), mem[(m_start + i) % DEPTH]});
            done_q.push_back({16'(edge_n + m_l), 8'(m_w)});
            m_next_free = edge_n + m_l + 2;
`ifndef MEM_ARB_FIXED_PRIO_EN
            m_rr = (m_w + 1) % NREQ;
`endif
        end
    end

    // Monitor
    logic [NREQ-1:0]  mon_gnt, mon_done;
    logic             mon_en, mon_hit, mon_dhit;
    logic [AW-1:0]    mon_addr;
    logic [EW-1:0]    mon_e;
    logic [23:0]      mon_d;

    always @(negedge clk) begin
        if (edge_n > 0) begin
            mon_gnt  = '0;
            mon_en   = 1'b0;
            mon_addr = '0;
            if (m_active != 0 && edge_n >= m_e && edge_n <= m_e + m_len)
                mon_gnt = NREQ'(1) << m_owner;
            if (m_active != 0 && edge_n >= m_e && edge_n < m_e + m_len) begin
                mon_en   = 1'b1;
                mon_addr = AW'((m_start + edge_n - m_e) % DEPTH);
            end
            check("gnt", gnt, mon_gnt);
            check("mem_en", mem_en, mon_en);
            if (mon_en) check("mem_addr", mem_addr, mon_addr);

            mon_hit = exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) == edge_n;
            check("rd_valid", rd_valid, mon_hit);
            if (mon_hit) begin
                mon_e = exp_q.pop_front();
                if (rd_valid) begin
                    check("rd_data", rd_data, mon_e[WIDTH-1:0]);
                    check("rd_owner", rd_owner, mon_e[WIDTH+7:WIDTH]);
                end
            end

            mon_dhit = done_q.size() > 0 && int'(done_q[0][23:8]) == edge_n;
            mon_done = '0;
            if (mon_dhit) begin
                mon_d    = done_q.pop_front();
                mon_done = NREQ'(1) << mon_d[7:0];
            end
            check("done", done, mon_done);
        end
    end

    // Driver tasks
    task automatic set_req(input int i, input int start, input int len);
        start_addr[i*AW +: AW]       = AW'(start);
        burst_len[i*(AW+1) +: AW+1]  = (AW+1)'(len);
        req[i]                       = 1'b1;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 200);
        check("wait_done", done[i], 1'b1);
    endtask

    task automatic wait_n_done(input int cnt);
        int n, seen;
        n = 0;
        seen = 0;
        while (seen < cnt && n < 200) begin
            @(negedge clk);
            n++;
            if (done != '0) seen++;
        end
        check("done_count", seen, cnt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"}, gnt, '0);
        check({tag, "_mem_en"}, mem_en, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_rd_owner"}, rd_owner, '0);
        check({tag, "_done"}, done, '0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 24'hA00000 + WIDTH'(i);

        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // Plain burst, wrapping burst, alternating pair
        set_req(0, 3, 4);  wait_done(0); req[0] = 1'b0;
        set_req(1, 14, 4); wait_done(1); req[1] = 1'b0;
        set_req(0, 1, 2); set_req(1, 8, 2);
        wait_n_done(4);
        req = '0;

        // Zero-length burst, then a one-word burst to move the pointer
        set_req(1, 7, 0); wait_done(1); req[1] = 1'b0;
        set_req(0, 0, 1); wait_done(0); req[0] = 1'b0;

        // Reset in the third beat cycle of a long burst
        set_req(0, 2, 8);
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[0] && n < 50);
        check("grant_seen", gnt[0], 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        check_reset_values("mid");
        reset = 1'b0;
        set_req(0, 10, 2); set_req(1, 12, 2);
        wait_n_done(2);
        req = '0;

        // Full-memory and clamped bursts
        set_req(0, 5, 16); wait_done(0); req[0] = 1'b0;
        set_req(1, 5, 31); wait_done(1); req[1] = 1'b0;

        // Randomized requesters
        repeat (500) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (done[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else if ($urandom_range(0, 7) == 0)
                        set_req(i, $urandom_range(0, DEPTH - 1), $urandom_range(0, 16));
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(i, $urandom_range(0, DEPTH - 1),
                            ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16));
                end
            end
        end
        req = '0;
        repeat (40) @(negedge clk);
        check("beats_drained", exp_q.size(), 0);
        check("done_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
